// File: rtl/lsu_pkg.sv
// Shared types and lane constants for the load/store control stage.
package lsu_pkg;

    localparam int NUM_BYTE_LANES = 4;
    localparam int BYTE_WIDTH     = 8;
    localparam int LSU_ADDR_WIDTH = 32;
    localparam int LSU_DATA_WIDTH = NUM_BYTE_LANES * BYTE_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic                      valid;
        logic                      wen;
        logic [LSU_ADDR_WIDTH-1:0] addr;
        logic [LSU_DATA_WIDTH-1:0] wdata;
        logic [NUM_BYTE_LANES-1:0] mask;
    } mem_req_s;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replicate/mask and load lane extract with zero-extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic                      is_byte,
    input  logic [1:0]                lane,
    input  logic [LSU_DATA_WIDTH-1:0] store_data,
    input  logic [LSU_DATA_WIDTH-1:0] resp_data,
    output logic [LSU_DATA_WIDTH-1:0] wdata,
    output logic [NUM_BYTE_LANES-1:0] mask,
    output logic [LSU_DATA_WIDTH-1:0] load_data
);

    always_comb begin
        wdata     = store_data;
        mask      = '1;
        load_data = resp_data;
        if (is_byte) begin
            wdata     = {NUM_BYTE_LANES{store_data[BYTE_WIDTH-1:0]}};
            mask      = NUM_BYTE_LANES'(1) << lane;
            load_data = {{(LSU_DATA_WIDTH-BYTE_WIDTH){1'b0}},
                         resp_data[BYTE_WIDTH*lane +: BYTE_WIDTH]};
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: one memory transaction at a time, stalling upstream while in flight.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RF_ADDR_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     is_load_i,
    input  logic                     is_store_i,
    input  logic                     is_byte_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [DATA_WIDTH-1:0]    store_data_i,
    input  logic [RF_ADDR_WIDTH-1:0] rd_i,
    output logic                     mem_valid_o,
    output logic                     mem_wen_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    output logic [3:0]               mem_mask_o,
    input  logic                     mem_yumi_i,
    input  logic                     mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]    mem_resp_data_i,
    output logic                     stall_o,
    output logic                     rf_wen_o,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]    load_data_o,
    output logic                     misalign_o,
    output logic                     timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e             state;
    mem_req_s               req;
    logic                   op_load;
    logic                   op_byte;
    logic [1:0]             op_lane;
    logic [RF_ADDR_WIDTH-1:0] op_rd;
    logic [CNT_W-1:0]       cnt;

    logic                   is_mem_op;
    logic                   aligned;
    logic                   accept;
    logic                   al_byte;
    logic [1:0]             al_lane;
    logic [DATA_WIDTH-1:0]  al_wdata;
    logic [DATA_WIDTH-1:0]  al_load;
    logic [3:0]             al_mask;

    assign is_mem_op = start_i && (is_load_i || is_store_i);
    assign aligned   = is_byte_i || (addr_i[1:0] == 2'b00);
    assign accept    = (state == IDLE) && is_mem_op && aligned;

    assign misalign_o = (state == IDLE) && is_mem_op && !aligned;
    assign stall_o    = accept || (state == REQ) || (state == RESP);

    assign mem_valid_o = req.valid;
    assign mem_wen_o   = req.wen;
    assign mem_addr_o  = req.addr[ADDR_WIDTH-1:0];
    assign mem_wdata_o = req.wdata;
    assign mem_mask_o  = req.mask;

    // The store path is evaluated on the incoming op; the load path on the latched one.
    assign al_byte = (state == IDLE) ? is_byte_i   : op_byte;
    assign al_lane = (state == IDLE) ? addr_i[1:0] : op_lane;

    lsu_lane_align u_align (
        .is_byte    (al_byte),
        .lane       (al_lane),
        .store_data (store_data_i),
        .resp_data  (mem_resp_data_i),
        .wdata      (al_wdata),
        .mask       (al_mask),
        .load_data  (al_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req         <= '0;
            op_load     <= 1'b0;
            op_byte     <= 1'b0;
            op_lane     <= '0;
            op_rd       <= '0;
            cnt         <= '0;
            rf_wen_o    <= 1'b0;
            rf_waddr_o  <= '0;
            load_data_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            rf_wen_o  <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    req.valid <= 1'b1;
                    req.wen   <= !is_load_i;
                    req.addr  <= LSU_ADDR_WIDTH'({addr_i[ADDR_WIDTH-1:2], 2'b00});
                    req.wdata <= al_wdata;
                    req.mask  <= is_load_i ? 4'b1111 : al_mask;
                    op_load   <= is_load_i;
                    op_byte   <= is_byte_i;
                    op_lane   <= addr_i[1:0];
                    op_rd     <= rd_i;
                    state     <= REQ;
                end
                REQ: if (mem_yumi_i) begin
                    req <= '0;
                    if (!op_load) begin
                        state <= DONE;
                    end else if (mem_resp_valid_i) begin
                        rf_wen_o    <= (op_rd != '0);
                        rf_waddr_o  <= op_rd;
                        load_data_o <= al_load;
                        state       <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid_i) begin
                        rf_wen_o    <= (op_rd != '0);
                        rf_waddr_o  <= op_rd;
                        load_data_o <= al_load;
                        state       <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed checks of lsu_ctrl: stores, byte/word loads, misalign, timeout, reset abort.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, is_load_i, is_store_i, is_byte_i;
    logic [31:0] addr_i, store_data_i;
    logic [4:0]  rd_i;
    logic        mem_valid_o, mem_wen_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_mask_o;
    logic        mem_yumi_i, mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        stall_o, rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] load_data_o;
    logic        misalign_o, timeout_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_i),
        .is_load_i        (is_load_i),
        .is_store_i       (is_store_i),
        .is_byte_i        (is_byte_i),
        .addr_i           (addr_i),
        .store_data_i     (store_data_i),
        .rd_i             (rd_i),
        .mem_valid_o      (mem_valid_o),
        .mem_wen_o        (mem_wen_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_mask_o       (mem_mask_o),
        .mem_yumi_i       (mem_yumi_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .stall_o          (stall_o),
        .rf_wen_o         (rf_wen_o),
        .rf_waddr_o       (rf_waddr_o),
        .load_data_o      (load_data_o),
        .misalign_o       (misalign_o),
        .timeout_o        (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        start_i = 0; is_load_i = 0; is_store_i = 0; is_byte_i = 0;
        addr_i = 0; store_data_i = 0; rd_i = 0;
        mem_yumi_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = 0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic op(input logic ld, input logic st, input logic byt,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        start_i = 1; is_load_i = ld; is_store_i = st; is_byte_i = byt;
        addr_i = a; store_data_i = d; rd_i = rd;
    endtask

    initial begin
        logic held;
        idle_in();
        reset = 1;
        cyc(); cyc();
        reset = 0; #1;
        chk("rst_valid", mem_valid_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_rfwen", rf_wen_o, 0);
        chk("rst_tmo",   timeout_o, 0);
        chk("rst_mask",  mem_mask_o, 0);
        chk("rst_ldata", load_data_o, 0);

        // SW 0x100, immediate yumi
        cyc(); op(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0); #1;
        chk("sw_acc_stall", stall_o, 1);
        chk("sw_acc_valid", mem_valid_o, 0);
        cyc(); idle_in(); mem_yumi_i = 1; #1;
        chk("sw_valid", mem_valid_o, 1);
        chk("sw_wen",   mem_wen_o, 1);
        chk("sw_addr",  mem_addr_o, 32'h100);
        chk("sw_mask",  mem_mask_o, 4'b1111);
        chk("sw_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("sw_stall", stall_o, 1);
        cyc(); idle_in(); #1;
        chk("sw_done_stall", stall_o, 0);
        chk("sw_done_valid", mem_valid_o, 0);
        chk("sw_done_rfwen", rf_wen_o, 0);

        // LBU 0x203 rd=7, response one cycle after yumi
        cyc(); op(1'b1, 1'b0, 1'b1, 32'h203, 32'h0, 5'd7); #1;
        chk("lbu_acc_stall", stall_o, 1);
        cyc(); idle_in(); mem_yumi_i = 1; #1;
        chk("lbu_valid", mem_valid_o, 1);
        chk("lbu_wen",   mem_wen_o, 0);
        chk("lbu_addr",  mem_addr_o, 32'h200);
        cyc(); idle_in(); mem_resp_valid_i = 1; mem_resp_data_i = 32'h11223344; #1;
        chk("lbu_resp_stall", stall_o, 1);
        chk("lbu_resp_valid", mem_valid_o, 0);
        cyc(); idle_in(); #1;
        chk("lbu_rfwen", rf_wen_o, 1);
        chk("lbu_waddr", rf_waddr_o, 7);
        chk("lbu_data",  load_data_o, 32'h00000011);
        chk("lbu_stall", stall_o, 0);
        cyc(); #1;
        chk("lbu_rfwen_pulse", rf_wen_o, 0);

        // SB 0x302, yumi after 3 request cycles
        cyc(); op(1'b0, 1'b1, 1'b1, 32'h302, 32'h000000AB, 5'd0); #1;
        chk("sb_acc_stall", stall_o, 1);
        held = 1;
        for (int k = 0; k < 3; k++) begin
            cyc(); idle_in(); mem_yumi_i = (k == 2); #1;
            held &= mem_valid_o && stall_o && (mem_mask_o == 4'b0100)
                  && (mem_wdata_o == 32'hABABABAB) && (mem_addr_o == 32'h300) && mem_wen_o;
        end
        chk("sb_held", held, 1);
        cyc(); idle_in(); #1;
        chk("sb_done_valid", mem_valid_o, 0);
        chk("sb_done_stall", stall_o, 0);

        // Misaligned LW then aligned LW next cycle (same-cycle response)
        cyc(); op(1'b1, 1'b0, 1'b0, 32'h006, 32'h0, 5'd3); #1;
        chk("mis_pulse", misalign_o, 1);
        chk("mis_stall", stall_o, 0);
        chk("mis_valid", mem_valid_o, 0);
        cyc(); op(1'b1, 1'b0, 1'b0, 32'h004, 32'h0, 5'd3); #1;
        chk("mis_next_pulse", misalign_o, 0);
        chk("mis_next_stall", stall_o, 1);
        cyc(); idle_in(); mem_yumi_i = 1; mem_resp_valid_i = 1; mem_resp_data_i = 32'hCAFEF00D; #1;
        chk("lw_addr", mem_addr_o, 32'h004);
        cyc(); idle_in(); #1;
        chk("lw_rfwen", rf_wen_o, 1);
        chk("lw_waddr", rf_waddr_o, 3);
        chk("lw_data",  load_data_o, 32'hCAFEF00D);

        // LW with no response -> timeout after 255 RESP cycles
        cyc(); op(1'b1, 1'b0, 1'b0, 32'h008, 32'h0, 5'd5);
        cyc(); idle_in(); mem_yumi_i = 1;
        held = 1;
        for (int k = 0; k < 255; k++) begin
            cyc(); idle_in(); #1;
            held &= stall_o && !timeout_o;
        end
        chk("tmo_wait_stall", held, 1);
        cyc(); idle_in(); mem_resp_valid_i = 1; mem_resp_data_i = 32'h99999999; #1;
        chk("tmo_pulse", timeout_o, 1);
        chk("tmo_stall", stall_o, 0);
        chk("tmo_rfwen", rf_wen_o, 0);
        cyc(); idle_in(); #1;
        chk("tmo_late_rfwen", rf_wen_o, 0);
        chk("tmo_clear", timeout_o, 0);
        chk("tmo_late_stall", stall_o, 0);

        // Reset while in RESP, then late response ignored
        cyc(); op(1'b1, 1'b0, 1'b0, 32'h00C, 32'h0, 5'd9);
        cyc(); idle_in(); mem_yumi_i = 1;
        cyc(); idle_in(); reset = 1; #1;
        chk("rr_in_resp_stall", stall_o, 1);
        cyc(); reset = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'h55; #1;
        chk("rr_valid", mem_valid_o, 0);
        chk("rr_stall", stall_o, 0);
        chk("rr_waddr", rf_waddr_o, 0);
        chk("rr_ldata", load_data_o, 0);
        cyc(); idle_in(); #1;
        chk("rr_late_rfwen", rf_wen_o, 0);
        chk("rr_late_ldata", load_data_o, 0);

        // LW to r0: data returned but no writeback
        cyc(); op(1'b1, 1'b0, 1'b0, 32'h010, 32'h0, 5'd0);
        cyc(); idle_in(); mem_yumi_i = 1; mem_resp_valid_i = 1; mem_resp_data_i = 32'h77; #1;
        cyc(); idle_in(); #1;
        chk("r0_rfwen", rf_wen_o, 0);
        chk("r0_data",  load_data_o, 32'h77);
        chk("r0_stall", stall_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
